// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : arbitration priority state (PRIO_CPU / PRIO_DMA)
//   ID_CPU/ID_DMA : requester identifiers carried through the read tag pipe
//   RW_WRITE/RW_READ : encoding of the rw request field
package dm_pkg;

  typedef enum logic {
    PRIO_CPU = 1'b0,
    PRIO_DMA = 1'b1
  } arb_state_t;

  localparam logic ID_CPU   = 1'b0;
  localparam logic ID_DMA   = 1'b1;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic logic is_read(input logic rw);
    return rw == RW_READ;
  endfunction

endpackage

// File: rtl/dm_arb_tag_pipe.sv
// Owner/read tag pipeline for the data-memory arbiter.
// Tracks which requester owns each granted read so the memory return two
// cycles later can be steered to the right requester.
//   clk, reset        : clock, asynchronous active-high reset
//   gnt               : a grant was issued this cycle
//   owner, rw         : requester id and rw field of the granted access
//   cpu_rvalid        : read return strobe for the CPU
//   dma_rvalid        : read return strobe for the DMA requester
module dm_arb_tag_pipe
  import dm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic gnt,
  input  logic owner,
  input  logic rw,
  output logic cpu_rvalid,
  output logic dma_rvalid
);

  logic vld_p0, vld_p1;
  logic owner_p0, owner_p1;

  // Valid tags are control: reset clears them so in-flight reads are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= gnt && is_read(rw);
      vld_p1 <= vld_p0;
    end
  end

  // Owner tags only matter while the matching valid is set.
  always_ff @(posedge clk) begin
    owner_p0 <= owner;
    owner_p1 <= owner_p0;
  end

  // Stage p1: memory read data is on mem_rdata now
  assign cpu_rvalid = vld_p1 && (owner_p1 == ID_CPU);
  assign dma_rvalid = vld_p1 && (owner_p1 == ID_DMA);

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter (pipeline CPU vs DMA/debug port).
// CPU wins ties unless the DMA port has been starved for STARVE_LIMIT
// cycles, in which case DMA gets the next grant. The winning access is
// registered onto the memory bus one cycle after the grant; read data is
// returned to the owner two cycles after the grant.
//   clk, reset                         : clock, asynchronous active-high reset
//   cpu_req/rw/addr/wdata, cpu_gnt     : CPU request and same-cycle grant
//   cpu_rdata, cpu_rvalid              : CPU read return
//   dma_*                              : same set for the DMA/debug requester
//   mem_en/rw/addr/wdata               : registered data-memory command
//   mem_rdata                          : memory read data (one cycle after en)
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       dma_req,
  input  logic       dma_rw,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic [7:0] dma_rdata,
  output logic       dma_rvalid,
  output logic       mem_en,
  output logic       mem_rw,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state, state_next;
  logic [3:0] starve_cnt, cnt_next;
  logic [7:0] cpu_rdata_hold, dma_rdata_hold;

  // Grants are combinational; forcing them low under reset keeps the bus idle.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (dma_req && (!cpu_req || state == PRIO_DMA))
        dma_gnt = 1'b1;
      else if (cpu_req)
        cpu_gnt = 1'b1;
    end
  end

  // The priority flip uses the counter value being written this cycle, so a
  // DMA that has waited STARVE_LIMIT cycles wins on the very next cycle.
  always_comb begin
    cnt_next   = '0;
    state_next = state;
    if (dma_req && !dma_gnt)
      cnt_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
    case (state)
      PRIO_CPU: if (cnt_next == LIMIT) state_next = PRIO_DMA;
      PRIO_DMA: if (dma_gnt)           state_next = PRIO_CPU;
      default:                         state_next = PRIO_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PRIO_CPU;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= cnt_next;
    end
  end

  // Stage p0 -> memory bus: register the winner's command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= cpu_gnt || dma_gnt;
      if (dma_gnt) begin
        mem_rw    <= dma_rw;
        mem_addr  <= dma_addr;
        mem_wdata <= dma_wdata;
      end else if (cpu_gnt) begin
        mem_rw    <= cpu_rw;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  dm_arb_tag_pipe u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .gnt        (cpu_gnt || dma_gnt),
    .owner      (dma_gnt ? ID_DMA : ID_CPU),
    .rw         (dma_gnt ? dma_rw : cpu_rw),
    .cpu_rvalid (cpu_rvalid),
    .dma_rvalid (dma_rvalid)
  );

  // Stage p1 -> requesters: pass memory data through on the strobe, and keep
  // the last returned value visible between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata_hold <= '0;
      dma_rdata_hold <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_hold <= mem_rdata;
      if (dma_rvalid) dma_rdata_hold <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_hold;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_hold;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  import dm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_rw;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dma_req, dma_rw;
  logic [7:0] dma_addr, dma_wdata;
  logic       dma_gnt, dma_rvalid;
  logic [7:0] dma_rdata;
  logic       mem_en, mem_rw;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  dm_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_rw     (dma_rw),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_en     (mem_en),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cr, crw;
    logic [7:0]  ca, cw;
    logic        dr, drw;
    logic [7:0]  da, dw;
    logic [7:0]  mrd;
    logic [1:0]  g;   // {cpu_gnt, dma_gnt}
    logic [17:0] m;   // {mem_en, mem_rw, mem_addr, mem_wdata}
    logic [17:0] r;   // {cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata}
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic cr, input logic crw, input logic [7:0] ca,
                              input logic [7:0] cw, input logic dr, input logic drw,
                              input logic [7:0] da, input logic [7:0] dw,
                              input logic [7:0] mrd, input logic [1:0] g,
                              input logic [17:0] m, input logic [17:0] r);
    vec_t v;
    v.cr = cr; v.crw = crw; v.ca = ca; v.cw = cw;
    v.dr = dr; v.drw = drw; v.da = da; v.dw = dw;
    v.mrd = mrd; v.g = g; v.m = m; v.r = r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.cr; cpu_rw = v.crw; cpu_addr = v.ca; cpu_wdata = v.cw;
    dma_req = v.dr; dma_rw = v.drw; dma_addr = v.da; dma_wdata = v.dw;
    mem_rdata = v.mrd;
  endtask

  function automatic logic [1:0] gnt_obs();
    return {cpu_gnt, dma_gnt};
  endfunction
  function automatic logic [17:0] mem_obs();
    return {mem_en, mem_rw, mem_addr, mem_wdata};
  endfunction
  function automatic logic [17:0] ret_obs();
    return {cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata};
  endfunction

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_rw = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
  endtask

  initial begin
    // Table: one row per clock cycle, outputs checked mid-cycle.
    //              cpu req/rw/addr/wdata        dma req/rw/addr/wdata        mrd    gnt    mem {en,rw,addr,wd}          ret {cv,cd,dv,dd}
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h00, 2'b00, {2'b00,8'h00,8'h00}, {1'b0,8'h00,1'b0,8'h00}));
    tv.push_back(mk(1'b1,1'b0,8'h03,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h00, 2'b10, {2'b00,8'h00,8'h00}, {1'b0,8'h00,1'b0,8'h00}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h00, 2'b00, {2'b10,8'h03,8'h00}, {1'b0,8'h00,1'b0,8'h00}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'hFF, 2'b00, {2'b00,8'h03,8'h00}, {1'b1,8'hFF,1'b0,8'h00}));
    tv.push_back(mk(1'b1,1'b1,8'h20,8'h10, 1'b1,1'b0,8'h21,8'h00, 8'h00, 2'b10, {2'b00,8'h03,8'h00}, {1'b0,8'hFF,1'b0,8'h00}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h21,8'h00, 8'h00, 2'b01, {2'b11,8'h20,8'h10}, {1'b0,8'hFF,1'b0,8'h00}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h00, 2'b00, {2'b10,8'h21,8'h00}, {1'b0,8'hFF,1'b0,8'h00}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h5A, 2'b00, {2'b00,8'h21,8'h00}, {1'b0,8'hFF,1'b1,8'h5A}));
    tv.push_back(mk(1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h00, 2'b10, {2'b00,8'h21,8'h00}, {1'b0,8'hFF,1'b0,8'h5A}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h02,8'h00, 8'h00, 2'b01, {2'b10,8'h01,8'h00}, {1'b0,8'hFF,1'b0,8'h5A}));
    tv.push_back(mk(1'b1,1'b0,8'h03,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h11, 2'b10, {2'b10,8'h02,8'h00}, {1'b1,8'h11,1'b0,8'h5A}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h22, 2'b00, {2'b10,8'h03,8'h00}, {1'b0,8'h11,1'b1,8'h22}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h33, 2'b00, {2'b00,8'h03,8'h00}, {1'b1,8'h33,1'b0,8'h22}));
    tv.push_back(mk(1'b0,1'b1,8'hEE,8'h55, 1'b0,1'b1,8'hDD,8'h66, 8'h44, 2'b00, {2'b00,8'h03,8'h00}, {1'b0,8'h33,1'b0,8'h22}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h40,8'h77, 8'h00, 2'b01, {2'b00,8'h03,8'h00}, {1'b0,8'h33,1'b0,8'h22}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h00, 2'b00, {2'b11,8'h40,8'h77}, {1'b0,8'h33,1'b0,8'h22}));
    tv.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h99, 2'b00, {2'b01,8'h40,8'h77}, {1'b0,8'h33,1'b0,8'h22}));

    // Reset with both requesters active: everything must be quiet.
    reset = 1'b1;
    idle_inputs();
    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 8'h12; dma_addr = 8'h34;
    mem_rdata = 8'hA5;
    @(negedge clk);
    chk("reset_gnt", 32'(gnt_obs()), 32'h0);
    chk("reset_mem", 32'(mem_obs()), 32'h0);
    chk("reset_ret", 32'(ret_obs()), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();

    // Table-driven cycles; the first row is applied right after release.
    for (int i = 0; i < tv.size(); i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      drive(tv[i]);
      @(negedge clk);
      chk($sformatf("row%0d_gnt", i), 32'(gnt_obs()), 32'(tv[i].g));
      chk($sformatf("row%0d_mem", i), 32'(mem_obs()), 32'(tv[i].m));
      chk($sformatf("row%0d_ret", i), 32'(ret_obs()), 32'(tv[i].r));
    end

    // Both requesters always asking: DMA must win every fifth cycle.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'(i);
      dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 8'h90; dma_wdata = 8'(i);
      mem_rdata = 8'h00;
      @(negedge clk);
      chk($sformatf("starve%0d_gnt", i), 32'(gnt_obs()),
          (i % 5 == 4) ? 32'h1 : 32'h2);
      chk($sformatf("starve%0d_cnt_max", i), 32'(dut.starve_cnt <= 4'd4), 32'h1);
      chk($sformatf("starve%0d_no_rvalid", i), 32'({cpu_rvalid, dma_rvalid}), 32'h0);
    end
    @(posedge clk); #1;
    idle_inputs();
    mem_rdata = 8'hC3;
    @(negedge clk);

    // Reset one cycle after a CPU read grant: the read must vanish.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h05;
    @(negedge clk);
    chk("rst_seq_grant", 32'(gnt_obs()), 32'h2);
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_addr = 8'h06;
    @(negedge clk);
    chk("rst_seq_gnt_in_reset", 32'(gnt_obs()), 32'h0);
    chk("rst_seq_mem_in_reset", 32'(mem_obs()), 32'h0);
    chk("rst_seq_ret_in_reset", 32'(ret_obs()), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq_no_stale_rvalid", 32'(ret_obs()), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_seq_first_grant", 32'(gnt_obs()), 32'h2);
    chk("rst_seq_ret_after", 32'(ret_obs()), 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("rst_seq_mem_after", 32'(mem_obs()), 32'({2'b10, 8'h06, 8'h00}));
    chk("rst_seq_ret_wait", 32'(ret_obs()), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq_new_return", 32'(ret_obs()), 32'({1'b1, 8'hC3, 1'b0, 8'h00}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
